// File: rtl/dsi_pkg.sv
// Shared DSI line-buffer types: pixel formats, bytes-per-pixel helper and FSM encodings.
package dsi_pkg;

    localparam int FRAME_LENGTH = 1920;

    typedef enum logic [1:0] {
        PIX_RGB565,
        PIX_RGB666,
        PIX_RGB888
    } pix_fmt_t;

    // Whole bytes occupied by one pixel on the link (RGB666 loosely rounds up to 3).
    function automatic int bpp(input int pix_w);
        return (pix_w + 7) / 8;
    endfunction

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PREF,
        R_STREAM
    } rd_state_t;

endpackage

// File: rtl/line_pingpong_buffer_if.sv
// Pixel stream from the line buffer to the long-packet payload builder.
interface line_pingpong_buffer_if #(
    parameter int PIX_W = 24
);
    logic [PIX_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [15:0]      m_len;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        output m_len,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        input  m_len,
        output m_ready
    );
endinterface

// File: rtl/line_bank_ram.sv
// Simple dual-port line storage: one write port, one read port with registered output.
module line_bank_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/line_pingpong_buffer.sv
// Multi-bank line buffer: captures one line per data_valid burst, streams committed
// lines out with last-pixel marking, and flags overflow, dropped lines and WC mismatches.
module line_pingpong_buffer
    import dsi_pkg::*;
#(
    parameter int PIX_W   = 24,
    parameter int MAX_PIX = FRAME_LENGTH,
    parameter int NBUF    = 2,
    parameter int BPP     = bpp(PIX_W)
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    input  logic [15:0]            WC,
    input  logic [PIX_W-1:0]       pixel_data,
    input  logic                   data_valid,
    line_pingpong_buffer_if.master m_if,
    output logic                   line_done,
    output logic                   ovf,
    output logic                   line_drop,
    output logic                   wc_err
);
    localparam int CNT_W  = $clog2(MAX_PIX + 1);
    localparam int BW     = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int DEPTH  = NBUF * MAX_PIX;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PIX);
    localparam logic [BW-1:0]    LAST_BANK = BW'(NBUF - 1);

    wr_state_t r_wstate, w_wstate_next;
    rd_state_t r_rstate, w_rstate_next;

    logic [BW-1:0]    r_wbank, r_rbank;
    logic [CNT_W-1:0] r_wcnt, r_rcnt;
    logic [15:0]      r_wc_pix;
    logic             r_wc_rem;
    logic             r_line_done, r_ovf, r_line_drop, r_wc_err;

    logic [NBUF-1:0]  w_full;
    logic [CNT_W-1:0] w_len [NBUF];

    logic             w_xfer, w_last, w_rd_free, w_re;
    logic [CNT_W-1:0] w_ridx;
    logic             w_bank_free, w_we, w_claim, w_commit, w_drop_line, w_ovf_pix;
    logic [CNT_W-1:0] w_widx;
    logic [ADDR_W-1:0] w_waddr, w_raddr;
    logic [PIX_W-1:0]  w_rdata;

    // ---------------- read side ----------------
    assign w_xfer    = (r_rstate == R_STREAM) && m_if.m_ready;
    assign w_last    = (r_rcnt == w_len[r_rbank] - 1'b1);
    assign w_rd_free = w_xfer && w_last;

    always_comb begin
        w_rstate_next = r_rstate;
        w_re          = 1'b0;
        w_ridx        = '0;
        case (r_rstate)
            R_IDLE: begin
                if (w_full[r_rbank]) begin
                    w_rstate_next = R_PREF;
                end
            end
            R_PREF: begin
                w_re          = 1'b1;
                w_rstate_next = R_STREAM;
            end
            R_STREAM: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_rstate_next = R_IDLE;
                    end else begin
                        w_re   = 1'b1;
                        w_ridx = r_rcnt + 1'b1;
                    end
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_rstate    <= R_IDLE;
            r_rbank     <= '0;
            r_rcnt      <= '0;
            r_line_done <= 1'b0;
        end else begin
            r_rstate    <= w_rstate_next;
            r_line_done <= w_rd_free;
            if (r_rstate == R_PREF) begin
                r_rcnt <= '0;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_rcnt  <= '0;
                    r_rbank <= (r_rbank == LAST_BANK) ? '0 : r_rbank + 1'b1;
                end else begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end
        end
    end

    // ---------------- write side ----------------
    // A bank drained at this very edge may be claimed by a line starting now.
    assign w_bank_free = !w_full[r_wbank] || (w_rd_free && (r_rbank == r_wbank));

    always_comb begin
        w_wstate_next = r_wstate;
        w_we          = 1'b0;
        w_widx        = r_wcnt;
        w_claim       = 1'b0;
        w_commit      = 1'b0;
        w_drop_line   = 1'b0;
        w_ovf_pix     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (data_valid) begin
                    if (w_bank_free) begin
                        w_claim       = 1'b1;
                        w_we          = 1'b1;
                        w_widx        = '0;
                        w_wstate_next = W_FILL;
                    end else begin
                        w_drop_line   = 1'b1;
                        w_wstate_next = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (data_valid) begin
                    if (r_wcnt == MAX_CNT) begin
                        w_ovf_pix = 1'b1;
                    end else begin
                        w_we = 1'b1;
                    end
                end else begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_IDLE;
                end
            end
            W_DROP: begin
                if (!data_valid) begin
                    w_wstate_next = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_wstate    <= W_IDLE;
            r_wbank     <= '0;
            r_wcnt      <= '0;
            r_wc_pix    <= '0;
            r_wc_rem    <= 1'b0;
            r_ovf       <= 1'b0;
            r_line_drop <= 1'b0;
            r_wc_err    <= 1'b0;
        end else begin
            r_wstate    <= w_wstate_next;
            r_ovf       <= w_ovf_pix;
            r_line_drop <= w_drop_line;
            r_wc_err    <= w_commit && (r_wc_rem || (32'(r_wcnt) != 32'(r_wc_pix)));
            if (w_claim) begin
                r_wcnt   <= CNT_W'(1);
                r_wc_pix <= WC / 16'(BPP);
                r_wc_rem <= (WC % 16'(BPP)) != 16'd0;
            end else if (w_we) begin
                r_wcnt <= r_wcnt + 1'b1;
            end else if (w_commit) begin
                r_wcnt  <= '0;
                r_wbank <= (r_wbank == LAST_BANK) ? '0 : r_wbank + 1'b1;
            end
        end
    end

    // ---------------- per-bank occupancy and length ----------------
    for (genvar gi = 0; gi < NBUF; gi++) begin : g_bank
        logic             r_full;
        logic [CNT_W-1:0] r_len;

        always_ff @(posedge pclk) begin
            if (!rst_n) begin
                r_full <= 1'b0;
                r_len  <= '0;
            end else begin
                if (w_rd_free && (r_rbank == BW'(gi))) begin
                    r_full <= 1'b0;
                end
                if (w_commit && (r_wbank == BW'(gi))) begin
                    r_full <= 1'b1;
                    r_len  <= r_wcnt;
                end
            end
        end

        assign w_full[gi] = r_full;
        assign w_len[gi]  = r_len;
    end

    assign w_waddr = ADDR_W'(int'(r_wbank) * MAX_PIX + int'(w_widx));
    assign w_raddr = ADDR_W'(int'(r_rbank) * MAX_PIX + int'(w_ridx));

    line_bank_ram #(
        .DATA_W (PIX_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (pclk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (pixel_data),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Stream outputs are forced to zero whenever nothing is being presented.
    assign m_if.m_valid = (r_rstate == R_STREAM);
    assign m_if.m_data  = m_if.m_valid ? w_rdata : '0;
    assign m_if.m_last  = m_if.m_valid && w_last;
    assign m_if.m_len   = m_if.m_valid ? 16'(w_len[r_rbank]) : 16'd0;

    assign line_done = r_line_done;
    assign ovf       = r_ovf;
    assign line_drop = r_line_drop;
    assign wc_err    = r_wc_err;
endmodule

// File: tb/tb_line_pingpong_buffer.sv
// Directed bench for line_pingpong_buffer (PIX_W=24, MAX_PIX=16, NBUF=2).
module tb_line_pingpong_buffer;
    logic        clk;
    logic        rst_n;
    logic [15:0] wc;
    logic [23:0] pixel_data;
    logic        data_valid;
    logic        m_ready;
    logic        line_done, ovf, line_drop, wc_err;

    int n_checks = 0;
    int n_errors = 0;

    line_pingpong_buffer_if #(.PIX_W(24)) m_if ();
    assign m_if.m_ready = m_ready;

    line_pingpong_buffer #(
        .PIX_W   (24),
        .MAX_PIX (16),
        .NBUF    (2)
    ) dut (
        .pclk       (clk),
        .rst_n      (rst_n),
        .WC         (wc),
        .pixel_data (pixel_data),
        .data_valid (data_valid),
        .m_if       (m_if),
        .line_done  (line_done),
        .ovf        (ovf),
        .line_drop  (line_drop),
        .wc_err     (wc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: records transfers, pulse counts and stall stability.
    logic [23:0] q_data [$];
    logic        q_last [$];
    logic [15:0] q_len  [$];
    int cnt_done = 0, cnt_ovf = 0, cnt_drop = 0, cnt_wcerr = 0, hold_viol = 0;
    int rise_cyc = -1, wcerr_cyc = -1;
    logic        prev_valid = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [23:0] prev_data = '0;
    logic [15:0] prev_len = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_if.m_valid && m_ready) begin
                q_data.push_back(m_if.m_data);
                q_last.push_back(m_if.m_last);
                q_len.push_back(m_if.m_len);
            end
            if (line_done) cnt_done  <= cnt_done + 1;
            if (ovf)       cnt_ovf   <= cnt_ovf + 1;
            if (line_drop) cnt_drop  <= cnt_drop + 1;
            if (wc_err) begin
                cnt_wcerr <= cnt_wcerr + 1;
                wcerr_cyc <= cyc;
            end
            if (m_if.m_valid && !prev_valid) rise_cyc <= cyc;
            if (prev_stall && m_if.m_valid &&
                (m_if.m_data != prev_data || m_if.m_len != prev_len || m_if.m_last != prev_last))
                hold_viol <= hold_viol + 1;
        end
        prev_valid <= m_if.m_valid;
        prev_stall <= m_if.m_valid && !m_ready;
        prev_data  <= m_if.m_data;
        prev_len   <= m_if.m_len;
        prev_last  <= m_if.m_last;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives an n-pixel burst starting at posedge+1; returns at posedge+1 after the last pixel.
    task automatic send_line(input int n, input int base, input int wc_val);
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b1;
            pixel_data = 24'(base + i);
            wc         = 16'(wc_val);
            tick(1);
        end
        data_valid = 1'b0;
        pixel_data = '0;
    endtask

    task automatic check_line(input string tag, input int n0, input int n, input int base, input int len);
        logic [31:0] d, l, ln;
        for (int i = 0; i < n; i++) begin
            if (n0 + i < q_data.size()) begin
                d  = 32'(q_data[n0 + i]);
                l  = 32'(q_last[n0 + i]);
                ln = 32'(q_len[n0 + i]);
            end else begin
                d  = 32'hDEAD_BEEF;
                l  = 32'hDEAD_BEEF;
                ln = 32'hDEAD_BEEF;
            end
            check($sformatf("%s_data%0d", tag, i), d, 32'(base + i));
            check($sformatf("%s_last%0d", tag, i), l, (i == n - 1) ? 32'd1 : 32'd0);
            check($sformatf("%s_len%0d", tag, i), ln, 32'(len));
        end
        $display("txn %s: %0d pixels from 0x%0h, len %0d", tag, n, base, len);
    endtask

    int n0, d0, e0, o0, p0, h0, k;

    initial begin
        rst_n = 1'b0; data_valid = 1'b0; pixel_data = '0; wc = '0; m_ready = 1'b0;
        tick(3);
        check("rst_m_valid",   32'(m_if.m_valid), 32'd0);
        check("rst_m_last",    32'(m_if.m_last),  32'd0);
        check("rst_m_len",     32'(m_if.m_len),   32'd0);
        check("rst_m_data",    32'(m_if.m_data),  32'd0);
        check("rst_line_done", 32'(line_done),    32'd0);
        check("rst_ovf",       32'(ovf),          32'd0);
        check("rst_line_drop", 32'(line_drop),    32'd0);
        check("rst_wc_err",    32'(wc_err),       32'd0);
        rst_n = 1'b1; m_ready = 1'b1;
        tick(2);

        // 8-pixel line, matching WC
        n0 = q_data.size(); d0 = cnt_done; e0 = cnt_wcerr;
        send_line(8, 'h100, 24); k = cyc;
        tick(25);
        check("t1_rise",  32'(rise_cyc), 32'(k + 3));
        check("t1_count", 32'(q_data.size() - n0), 32'd8);
        check_line("t1", n0, 8, 'h100, 8);
        check("t1_done",  32'(cnt_done - d0), 32'd1);
        check("t1_wcerr", 32'(cnt_wcerr - e0), 32'd0);

        // 8-pixel line, WC=30 -> mismatch but still streamed
        n0 = q_data.size(); d0 = cnt_done; e0 = cnt_wcerr;
        send_line(8, 'h200, 30); k = cyc;
        tick(25);
        check("t2_wcerr",     32'(cnt_wcerr - e0), 32'd1);
        check("t2_wcerr_cyc", 32'(wcerr_cyc), 32'(k + 1));
        check("t2_rise",      32'(rise_cyc), 32'(k + 3));
        check("t2_count",     32'(q_data.size() - n0), 32'd8);
        check_line("t2", n0, 8, 'h200, 8);

        // 20-pixel burst into 16-deep bank
        n0 = q_data.size(); d0 = cnt_done; o0 = cnt_ovf;
        send_line(20, 'h300, 60);
        tick(40);
        check("t3_ovf",   32'(cnt_ovf - o0), 32'd4);
        check("t3_count", 32'(q_data.size() - n0), 32'd16);
        check_line("t3", n0, 16, 'h300, 16);
        check("t3_done",  32'(cnt_done - d0), 32'd1);

        // Full: three lines with downstream stalled
        m_ready = 1'b0;
        n0 = q_data.size(); d0 = cnt_done; p0 = cnt_drop;
        send_line(4, 'h400, 12); tick(1);
        send_line(4, 'h410, 12); tick(1);
        send_line(4, 'h420, 12);
        tick(10);
        check("t4_drop",      32'(cnt_drop - p0), 32'd1);
        check("t4_stalled",   32'(q_data.size() - n0), 32'd0);
        check("t4_hold_vld",  32'(m_if.m_valid), 32'd1);
        check("t4_hold_data", 32'(m_if.m_data), 32'h400);
        check("t4_hold_len",  32'(m_if.m_len), 32'd4);
        m_ready = 1'b1;
        tick(30);
        check("t4_count", 32'(q_data.size() - n0), 32'd8);
        check_line("t4a", n0, 4, 'h400, 4);
        check_line("t4b", n0 + 4, 4, 'h410, 4);
        check("t4_done",  32'(cnt_done - d0), 32'd2);

        // Back-to-back lines with m_ready toggling
        n0 = q_data.size(); d0 = cnt_done; h0 = hold_viol;
        m_ready = 1'b1;
        fork
            begin
                send_line(6, 'h500, 18); tick(1);
                send_line(6, 'h510, 18);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    m_ready = ~m_ready;
                    tick(1);
                end
                m_ready = 1'b1;
            end
        join
        tick(20);
        check("t5_count", 32'(q_data.size() - n0), 32'd12);
        check_line("t5a", n0, 6, 'h500, 6);
        check_line("t5b", n0 + 6, 6, 'h510, 6);
        check("t5_done",  32'(cnt_done - d0), 32'd2);
        check("t5_hold",  32'(hold_viol - h0), 32'd0);

        // Reset mid-line and mid-readout
        m_ready = 1'b0;
        send_line(4, 'h700, 12);
        tick(6);
        check("t6_stalled", 32'(m_if.m_valid), 32'd1);
        data_valid = 1'b1; pixel_data = 24'h7F0; wc = 16'd12;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("t6_m_valid",   32'(m_if.m_valid), 32'd0);
        check("t6_m_last",    32'(m_if.m_last),  32'd0);
        check("t6_m_len",     32'(m_if.m_len),   32'd0);
        check("t6_m_data",    32'(m_if.m_data),  32'd0);
        check("t6_line_done", 32'(line_done),    32'd0);
        check("t6_ovf",       32'(ovf),          32'd0);
        check("t6_line_drop", 32'(line_drop),    32'd0);
        check("t6_wc_err",    32'(wc_err),       32'd0);
        data_valid = 1'b0; pixel_data = '0;
        rst_n = 1'b1; m_ready = 1'b1;
        tick(2);
        n0 = q_data.size(); d0 = cnt_done;
        send_line(4, 'h800, 12);
        tick(20);
        check("t6_count", 32'(q_data.size() - n0), 32'd4);
        check_line("t6", n0, 4, 'h800, 4);
        check("t6_done",  32'(cnt_done - d0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
